// File: rtl/axis_loopback_fifo.sv
// AXI-Stream loopback FIFO with first-word-fall-through output, optional store-and-forward.
// Define AXIS_LOOPBACK_FIFO_STATS_EN to build the pkt_count/word_count statistics counters.
module axis_loopback_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int STORE_FWD  = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     s_axis_tvalid,
    input  logic                     s_axis_tlast,
    input  logic [DATA_WIDTH-1:0]    s_axis_tdata,
    output logic                     s_axis_tready,
    output logic                     m_axis_tvalid,
    output logic                     m_axis_tlast,
    output logic [DATA_WIDTH-1:0]    m_axis_tdata,
    input  logic                     m_axis_tready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     oversize,
    output logic [15:0]              pkt_count,
    output logic [31:0]              word_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    typedef enum logic {WAIT, SEND} state_t;

    logic [DATA_WIDTH:0] mem_q [DEPTH];
    logic [AW-1:0]       wrPtr_q;
    logic [AW-1:0]       rdPtr_q;
    logic [LW-1:0]       level_q;
    logic [LW-1:0]       level_d;
    logic [LW-1:0]       pktsStored_q;
    logic [LW-1:0]       pktsStored_d;
    logic                full;
    logic                empty;
    logic                wrEn;
    logic                rdEn;
    logic                wrLast;
    logic                rdLast;

    // Ready is computed from the registered level only, so a read cannot open a full FIFO in the same cycle.
    assign full          = (level_q == FULL_LEVEL);
    assign empty         = (level_q == '0);
    assign s_axis_tready = rst_n && !full;
    assign wrEn          = s_axis_tvalid && s_axis_tready;
    assign rdEn          = m_axis_tvalid && m_axis_tready;
    assign wrLast        = wrEn && s_axis_tlast;
    assign rdLast        = rdEn && m_axis_tlast;
    assign {m_axis_tlast, m_axis_tdata} = mem_q[rdPtr_q];
    assign level         = level_q;

    always_comb begin
        level_d      = level_q;
        pktsStored_d = pktsStored_q;
        if (wrEn && !rdEn) begin
            level_d = level_q + LW'(1);
        end else if (!wrEn && rdEn) begin
            level_d = level_q - LW'(1);
        end
        if (wrLast && !rdLast) begin
            pktsStored_d = pktsStored_q + LW'(1);
        end else if (!wrLast && rdLast) begin
            pktsStored_d = pktsStored_q - LW'(1);
        end
    end

    // Storage is not reset: an entry only matters once level says it holds a word.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem_q[wrPtr_q] <= {s_axis_tlast, s_axis_tdata};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wrPtr_q      <= '0;
            rdPtr_q      <= '0;
            level_q      <= '0;
            pktsStored_q <= '0;
        end else begin
            if (wrEn) begin
                wrPtr_q <= wrPtr_q + AW'(1);
            end
            if (rdEn) begin
                rdPtr_q <= rdPtr_q + AW'(1);
            end
            level_q      <= level_d;
            pktsStored_q <= pktsStored_d;
        end
    end

    generate
        if (STORE_FWD != 0) begin : gStoreFwd
            state_t state_q;
            logic   oversize_q;

            // A full FIFO with no complete packet can never finish in place, so it is released cut-through and flagged.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    state_q    <= WAIT;
                    oversize_q <= 1'b0;
                end else begin
                    case (state_q)
                        WAIT: begin
                            if (pktsStored_q != '0 || full) begin
                                state_q <= SEND;
                                if (full && pktsStored_q == '0) begin
                                    oversize_q <= 1'b1;
                                end
                            end
                        end
                        SEND: begin
                            if (rdLast) begin
                                state_q <= WAIT;
                            end
                        end
                    endcase
                end
            end

            assign m_axis_tvalid = rst_n && (state_q == SEND) && !empty;
            assign oversize      = oversize_q;
        end else begin : gCutThrough
            assign m_axis_tvalid = rst_n && !empty;
            assign oversize      = 1'b0;
        end
    endgenerate

`ifdef AXIS_LOOPBACK_FIFO_STATS_EN
    logic [15:0] pktCount_q;
    logic [31:0] wordCount_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pktCount_q  <= '0;
            wordCount_q <= '0;
        end else if (rdEn) begin
            wordCount_q <= wordCount_q + 32'd1;
            if (m_axis_tlast) begin
                pktCount_q <= pktCount_q + 16'd1;
            end
        end
    end

    assign pkt_count  = pktCount_q;
    assign word_count = wordCount_q;
`else
    assign pkt_count  = '0;
    assign word_count = '0;
`endif

endmodule

// File: tb/tb_axis_loopback_fifo.sv
// Bench for axis_loopback_fifo: a cut-through and a store-and-forward instance, each
// checked every cycle against a queue-based model of the stream, plus directed literal checks.
module tb_axis_loopback_fifo;
`ifdef AXIS_LOOPBACK_FIFO_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic             clock;
    logic             rst_n;
    logic [1:0]       sValid;
    logic [1:0]       sLast;
    logic [1:0][31:0] sData;
    logic [1:0]       mReady;
    wire  [1:0]       sReady;
    wire  [1:0]       mValid;
    wire  [1:0]       mLast;
    wire  [1:0][31:0] mData;
    wire  [1:0][4:0]  levelOut;
    wire  [1:0]       oversizeOut;
    wire  [1:0][15:0] pktCount;
    wire  [1:0][31:0] wordCount;

    int tests = 0;
    int errors = 0;
    int nW0;
    int nW1;

    logic [32:0] expQ [2][$];
    bit          sending [2];
    bit          expOversize [2];
    int          expPkts [2];
    int          expWords [2];
    int          lvl;
    int          pk;
    bit          expValid;
    logic [32:0] front;
    logic [32:0] ent;

    axis_loopback_fifo #(.DATA_WIDTH(32), .DEPTH(16), .STORE_FWD(0)) uCut (
        .clk(clock), .rst_n(rst_n),
        .s_axis_tvalid(sValid[0]), .s_axis_tlast(sLast[0]), .s_axis_tdata(sData[0]),
        .s_axis_tready(sReady[0]),
        .m_axis_tvalid(mValid[0]), .m_axis_tlast(mLast[0]), .m_axis_tdata(mData[0]),
        .m_axis_tready(mReady[0]),
        .level(levelOut[0]), .oversize(oversizeOut[0]),
        .pkt_count(pktCount[0]), .word_count(wordCount[0])
    );

    axis_loopback_fifo #(.DATA_WIDTH(32), .DEPTH(16), .STORE_FWD(1)) uStore (
        .clk(clock), .rst_n(rst_n),
        .s_axis_tvalid(sValid[1]), .s_axis_tlast(sLast[1]), .s_axis_tdata(sData[1]),
        .s_axis_tready(sReady[1]),
        .m_axis_tvalid(mValid[1]), .m_axis_tlast(mLast[1]), .m_axis_tdata(mData[1]),
        .m_axis_tready(mReady[1]),
        .level(levelOut[1]), .oversize(oversizeOut[1]),
        .pkt_count(pktCount[1]), .word_count(wordCount[1])
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #800000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        tests++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Called just after a rising edge; returns just after the edge that accepted the word.
    task automatic applyStimulus(input int sel, input logic [31:0] data, input bit last);
        int n = 0;
        bit hs = 1'b0;
        sValid[sel] = 1'b1;
        sData[sel]  = data;
        sLast[sel]  = last;
        while (!hs && n < 100) begin
            @(negedge clock);
            hs = sReady[sel];
            @(posedge clock);
            #1;
            n++;
        end
        sValid[sel] = 1'b0;
        checkOutput($sformatf("sendAccepted%0d", sel), hs, 1);
    endtask

    task automatic waitDrain(input int sel);
        int n = 0;
        mReady[sel] = 1'b1;
        while (expQ[sel].size() != 0 && n < 500) begin
            @(posedge clock);
            #1;
            n++;
        end
        checkOutput($sformatf("drained%0d", sel), expQ[sel].size(), 0);
    endtask

    task automatic randomTraffic(input int sel, input int nPkts, output int nWords);
        int pkt = 0;
        int idx = 0;
        int len = $urandom_range(8, 1);
        int cycles = 0;
        bit hs;
        nWords = 0;
        sValid[sel] = 1'b0;
        while (pkt < nPkts && cycles < 40000) begin
            if (!sValid[sel] && $urandom_range(3, 0) != 0) begin
                sValid[sel] = 1'b1;
                sData[sel]  = $urandom;
                sLast[sel]  = (idx == len - 1);
            end
            mReady[sel] = ($urandom_range(3, 0) != 0);
            @(negedge clock);
            hs = sValid[sel] && sReady[sel];
            @(posedge clock);
            #1;
            cycles++;
            if (hs) begin
                sValid[sel] = 1'b0;
                nWords++;
                if (idx == len - 1) begin
                    pkt++;
                    idx = 0;
                    len = $urandom_range(8, 1);
                end else begin
                    idx++;
                end
            end
        end
        sValid[sel] = 1'b0;
        checkOutput($sformatf("randomPackets%0d", sel), pkt, nPkts);
    endtask

    // Compare the outputs against the model, then advance the model across the coming edge.
    always @(negedge clock) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                checkOutput($sformatf("resetReady%0d", i), sReady[i], 0);
                checkOutput($sformatf("resetValid%0d", i), mValid[i], 0);
                expQ[i].delete();
                sending[i]     = 1'b0;
                expOversize[i] = 1'b0;
                expPkts[i]     = 0;
                expWords[i]    = 0;
            end else begin
                lvl      = expQ[i].size();
                expValid = (lvl != 0) && (i == 0 || sending[i]);
                front    = (lvl != 0) ? expQ[i][0] : 33'd0;
                checkOutput($sformatf("level%0d", i), levelOut[i], lvl);
                checkOutput($sformatf("sReady%0d", i), sReady[i], lvl != 16);
                checkOutput($sformatf("mValid%0d", i), mValid[i], expValid);
                if (expValid) begin
                    checkOutput($sformatf("mLastData%0d", i), {mLast[i], mData[i]}, front);
                end
                checkOutput($sformatf("oversize%0d", i), oversizeOut[i], expOversize[i]);
                checkOutput($sformatf("pktCount%0d", i), pktCount[i], STATS ? (expPkts[i] % 65536) : 0);
                checkOutput($sformatf("wordCount%0d", i), wordCount[i], STATS ? expWords[i] : 0);

                pk = 0;
                for (int k = 0; k < lvl; k++) begin
                    ent = expQ[i][k];
                    pk += int'(ent[32]);
                end
                if (i == 1) begin
                    if (!sending[i]) begin
                        if (pk != 0 || lvl == 16) begin
                            sending[i] = 1'b1;
                            if (pk == 0) expOversize[i] = 1'b1;
                        end
                    end else if (mValid[i] && mReady[i] && lvl != 0 && front[32]) begin
                        sending[i] = 1'b0;
                    end
                end
                if (mValid[i] && mReady[i] && lvl != 0) begin
                    front = expQ[i].pop_front();
                    expWords[i]++;
                    if (front[32]) expPkts[i]++;
                end
                if (sValid[i] && sReady[i]) begin
                    expQ[i].push_back({sLast[i], sData[i]});
                end
            end
        end
    end

    initial begin
        rst_n  = 1'b0;
        sValid = '0;
        sLast  = '0;
        sData  = '0;
        mReady = '0;
        repeat (3) @(posedge clock);
        #1 rst_n = 1'b1;
        @(negedge clock);
        checkOutput("readyAfterReset0", sReady[0], 1);
        checkOutput("readyAfterReset1", sReady[1], 1);
        @(posedge clock);
        #1;

        // Cut-through single word
        mReady[0] = 1'b1;
        applyStimulus(0, 32'hA5A5_0001, 1'b1);
        @(negedge clock);
        checkOutput("ctValid", mValid[0], 1);
        checkOutput("ctData", mData[0], 32'hA5A5_0001);
        checkOutput("ctLast", mLast[0], 1);
        @(negedge clock);
        checkOutput("ctLevel", levelOut[0], 0);
        checkOutput("ctIdle", mValid[0], 0);
        @(posedge clock);
        #1;

        // Fill to DEPTH with the sink stalled, then release one word
        mReady[0] = 1'b0;
        for (int k = 0; k < 16; k++) applyStimulus(0, 32'h1000 + k, k == 15);
        @(negedge clock);
        checkOutput("fullLevel", levelOut[0], 16);
        checkOutput("fullReady", sReady[0], 0);
        @(posedge clock);
        #1 mReady[0] = 1'b1;
        @(posedge clock);
        #1 mReady[0] = 1'b0;
        @(negedge clock);
        checkOutput("oneReadReady", sReady[0], 1);
        checkOutput("oneReadLevel", levelOut[0], 15);
        @(posedge clock);
        #1;
        waitDrain(0);

        // Store-and-forward with gaps: nothing leaves before tlast
        mReady[1] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1, 32'h5F00 + k, k == 4);
            if (k < 4) begin
                @(negedge clock);
                checkOutput("sfHeld", mValid[1], 0);
                @(posedge clock);
                #1;
                idle(1);
            end
        end
        waitDrain(1);
        @(negedge clock);
        checkOutput("sfPktCount", pktCount[1], STATS ? 1 : 0);
        checkOutput("sfWordCount", wordCount[1], STATS ? 5 : 0);
        @(posedge clock);
        #1;

        // Oversize packet: 20 words with no tlast until the end
        for (int k = 0; k < 20; k++) begin
            applyStimulus(1, 32'hB000 + k, k == 19);
            if (k == 15) begin
                @(negedge clock);
                checkOutput("ovfLevelFull", levelOut[1], 16);
                checkOutput("ovfFlagBefore", oversizeOut[1], 0);
                @(negedge clock);
                checkOutput("ovfFlag", oversizeOut[1], 1);
                checkOutput("ovfValid", mValid[1], 1);
                @(posedge clock);
                #1;
            end
        end
        waitDrain(1);
        applyStimulus(1, 32'hC000, 1'b0);
        @(negedge clock);
        checkOutput("ovfBackToWait", mValid[1], 0);
        @(posedge clock);
        #1;
        applyStimulus(1, 32'hC001, 1'b1);
        waitDrain(1);
        @(negedge clock);
        checkOutput("ovfSticky", oversizeOut[1], 1);
        checkOutput("ovfPktCount", pktCount[1], STATS ? 3 : 0);
        checkOutput("ovfWordCount", wordCount[1], STATS ? 27 : 0);
        @(posedge clock);
        #1;

        // Reset in the middle of a buffered packet
        for (int k = 0; k < 3; k++) applyStimulus(1, 32'hD000 + k, 1'b0);
        rst_n = 1'b0;
        @(posedge clock);
        #1 rst_n = 1'b1;
        @(negedge clock);
        checkOutput("rstLevel", levelOut[1], 0);
        checkOutput("rstValid", mValid[1], 0);
        checkOutput("rstPktCount", pktCount[1], 0);
        checkOutput("rstWordCount", wordCount[1], 0);
        checkOutput("rstOversize", oversizeOut[1], 0);
        @(posedge clock);
        #1;
        for (int k = 0; k < 6; k++) applyStimulus(1, 32'hE000 + k, k == 5);
        waitDrain(1);
        @(negedge clock);
        checkOutput("postRstPktCount", pktCount[1], STATS ? 1 : 0);
        checkOutput("postRstWordCount", wordCount[1], STATS ? 6 : 0);
        @(posedge clock);
        #1;

        // Random packets with random stalls on both instances
        rst_n = 1'b0;
        @(posedge clock);
        #1 rst_n = 1'b1;
        fork
            randomTraffic(0, 1000, nW0);
            randomTraffic(1, 1000, nW1);
        join
        fork
            waitDrain(0);
            waitDrain(1);
        join
        @(negedge clock);
        checkOutput("randPktCount0", pktCount[0], STATS ? 1000 : 0);
        checkOutput("randPktCount1", pktCount[1], STATS ? 1000 : 0);
        checkOutput("randWordCount0", wordCount[0], STATS ? nW0 : 0);
        checkOutput("randWordCount1", wordCount[1], STATS ? nW1 : 0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
